// File: rtl/soothe_pkg.sv
// soothe_pkg: shared state/move types and stress width for the soothe controller.
// Defining SOOTHE_CRY_WEIGHT_EN doubles the cry weight and widens the stress by one bit.
package soothe_pkg;

    typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, DECIDE, ADJUST, FAULT} state_t;
    typedef enum logic [1:0] {A_DOWN, F_UP, F_DOWN} move_t;

    function automatic int stress_w(input int sensor_w);
`ifdef SOOTHE_CRY_WEIGHT_EN
        return sensor_w + 2;
`else
        return sensor_w + 1;
`endif
    endfunction

    function automatic move_t next_move(input move_t m);
        return m == A_DOWN ? F_UP : m == F_UP ? F_DOWN : A_DOWN;
    endfunction

endpackage

// File: rtl/soothe_accum.sv
// soothe_accum: counts discarded settle samples, then sums per-sample stress over one window.
// SOOTHE_CRY_WEIGHT_EN selects 2*cry_level+heart_rate as the per-sample stress.
module soothe_accum
    import soothe_pkg::*;
#(
    parameter int SENSOR_W       = 8,
    parameter int AVG_LOG2       = 2,
    parameter int SETTLE_SAMPLES = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 clear,
    input  logic                                 settle,
    input  logic                                 measure,
    input  logic                                 sample_valid,
    input  logic [SENSOR_W-1:0]                  cry_level,
    input  logic [SENSOR_W-1:0]                  heart_rate,
    output logic                                 settle_done,
    output logic                                 measure_done,
    output logic [stress_w(SENSOR_W)+AVG_LOG2-1:0] sum
);

    localparam int STRESS_W = stress_w(SENSOR_W);
    localparam int ACC_W    = STRESS_W + AVG_LOG2;
    localparam int NSAMP    = 1 << AVG_LOG2;
    localparam int CNT_MAX  = SETTLE_SAMPLES > NSAMP ? SETTLE_SAMPLES : NSAMP;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_SAMPLES - 1);
    localparam logic [CNT_W-1:0] MEAS_LAST   = CNT_W'(NSAMP - 1);

    logic [CNT_W-1:0]    cnt;
    logic [STRESS_W-1:0] stress;

`ifdef SOOTHE_CRY_WEIGHT_EN
    assign stress = {1'b0, cry_level, 1'b0} + STRESS_W'(heart_rate);
`else
    assign stress = STRESS_W'(cry_level) + STRESS_W'(heart_rate);
`endif

    assign settle_done  = settle && sample_valid && cnt == SETTLE_LAST;
    assign measure_done = measure && sample_valid && cnt == MEAS_LAST;

    // sum keeps the finished window through DECIDE and is zeroed as MEASURE begins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            sum <= '0;
        end else if (clear || settle_done) begin
            cnt <= '0;
            sum <= '0;
        end else if ((settle || measure) && sample_valid) begin
            cnt <= measure_done ? '0 : cnt + 1'b1;
            if (measure) sum <= sum + ACC_W'(stress);
        end
    end

endmodule

// File: rtl/soothe_controller.sv
// soothe_controller: hill-climbing rocking controller that lowers measured stress by stepping amp/freq.
// Build option SOOTHE_CRY_WEIGHT_EN weights cry_level double in the stress measurement.
module soothe_controller
    import soothe_pkg::*;
#(
    parameter int SENSOR_W       = 8,
    parameter int LEVEL_W        = 3,
    parameter int AVG_LOG2       = 2,
    parameter int SETTLE_SAMPLES = 4,
    parameter int MAX_FAILS      = 7,
    parameter int INIT_AMP       = 4,
    parameter int INIT_FREQ      = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic                enable,
    input  logic [SENSOR_W-1:0] cry_level,
    input  logic [SENSOR_W-1:0] heart_rate,
    input  logic                err_clear,
    output logic [LEVEL_W-1:0]  amp,
    output logic [LEVEL_W-1:0]  freq,
    output logic                stress_down,
    output logic                at_rest,
    output logic                busy,
    output logic                error
);

    localparam int ACC_W  = stress_w(SENSOR_W) + AVG_LOG2;
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);
    localparam logic [FAIL_W-1:0]  FAIL_LAST = FAIL_W'(MAX_FAILS - 1);
    localparam logic [LEVEL_W-1:0] AMP0      = LEVEL_W'(INIT_AMP);
    localparam logic [LEVEL_W-1:0] FREQ0     = LEVEL_W'(INIT_FREQ);

    state_t              state, state_n;
    move_t               ptr, ptr_n;
    logic [LEVEL_W-1:0]  amp_n, freq_n, amp_mv, freq_mv;
    logic [FAIL_W-1:0]   fails, fails_n;
    logic [ACC_W-1:0]    sum, baseline, baseline_n;
    logic                base_ok, base_ok_n, sd_n, rest_n;
    logic                settle_done, measure_done;

    soothe_accum #(
        .SENSOR_W      (SENSOR_W),
        .AVG_LOG2      (AVG_LOG2),
        .SETTLE_SAMPLES(SETTLE_SAMPLES)
    ) u_accum (
        .clk         (clk),
        .reset       (reset),
        .clear       (!enable || state == IDLE || state == FAULT),
        .settle      (state == SETTLE),
        .measure     (state == MEASURE),
        .sample_valid(sample_valid),
        .cry_level   (cry_level),
        .heart_rate  (heart_rate),
        .settle_done (settle_done),
        .measure_done(measure_done),
        .sum         (sum)
    );

    assign busy  = state != IDLE && state != FAULT;
    assign error = state == FAULT;

    always_comb begin
        amp_mv  = (ptr == A_DOWN && amp != '0) ? amp - 1'b1 : amp;
        freq_mv = (ptr == F_UP && freq != '1) ? freq + 1'b1 :
                  (ptr == F_DOWN && freq != '0) ? freq - 1'b1 : freq;
    end

    always_comb begin
        state_n    = state;
        amp_n      = amp;
        freq_n     = freq;
        ptr_n      = ptr;
        fails_n    = fails;
        baseline_n = baseline;
        base_ok_n  = base_ok;
        sd_n       = 1'b0;
        rest_n     = 1'b0;
        if (state != FAULT && !enable) begin
            state_n    = IDLE;
            fails_n    = '0;
            baseline_n = '0;
            base_ok_n  = 1'b0;
        end else begin
            case (state)
                IDLE:    state_n = SETTLE;
                SETTLE:  state_n = settle_done ? MEASURE : SETTLE;
                MEASURE: state_n = measure_done ? DECIDE : MEASURE;
                DECIDE: begin
                    state_n    = ADJUST;
                    baseline_n = sum;
                    base_ok_n  = 1'b1;
                    if (base_ok && sum < baseline) begin
                        sd_n    = 1'b1;
                        fails_n = '0;
                    end else if (base_ok && fails == FAIL_LAST) begin
                        state_n    = FAULT;
                        fails_n    = fails + 1'b1;
                        baseline_n = baseline;
                        amp_n      = '0;
                        freq_n     = '0;
                    end else if (base_ok) begin
                        fails_n = fails + 1'b1;
                        ptr_n   = next_move(ptr);
                    end
                end
                ADJUST: begin
                    state_n = SETTLE;
                    amp_n   = amp_mv;
                    freq_n  = freq_mv;
                    // fully at rest: restart the search from scratch
                    if (amp_mv == '0 && freq_mv == '0) begin
                        rest_n     = 1'b1;
                        ptr_n      = A_DOWN;
                        fails_n    = '0;
                        baseline_n = '0;
                        base_ok_n  = 1'b0;
                    end
                end
                FAULT: begin
                    if (err_clear) begin
                        state_n    = IDLE;
                        amp_n      = AMP0;
                        freq_n     = FREQ0;
                        ptr_n      = A_DOWN;
                        fails_n    = '0;
                        baseline_n = '0;
                        base_ok_n  = 1'b0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            amp         <= AMP0;
            freq        <= FREQ0;
            ptr         <= A_DOWN;
            fails       <= '0;
            baseline    <= '0;
            base_ok     <= 1'b0;
            stress_down <= 1'b0;
            at_rest     <= 1'b0;
        end else begin
            state       <= state_n;
            amp         <= amp_n;
            freq        <= freq_n;
            ptr         <= ptr_n;
            fails       <= fails_n;
            baseline    <= baseline_n;
            base_ok     <= base_ok_n;
            stress_down <= sd_n;
            at_rest     <= rest_n;
        end
    end

endmodule
